// File: rtl/edge_window_controller.sv
// edge_window_controller: walks the interior pixels of an IMG_W x IMG_H image,
// builds the 3x3 neighbourhood for each one, runs one edge_detection
// transaction per pixel and writes the returned magnitude to the output buffer.
module edge_window_controller #(
    parameter int                IMG_W    = 16,
    parameter int                IMG_H    = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] OUT_BASE = 16'h0400
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_start,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic [71:0]       o_window,
    output logic              o_gradient_start,
    input  logic              i_gradient_data_ready,
    input  logic [7:0]        i_processed_sum,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPTURE, S_START, S_WAIT, S_WRITE, S_NEXT, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(IMG_H - 2);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] r_reg, r_next;
    logic [ADDR_W-1:0] c_reg, c_next;
    logic [3:0]        cnt_reg, cnt_next;          // reads in this fetch: 9 or 3
    logic [1:0]        row_off_reg, row_off_next;  // neighbourhood row of the read being issued
    logic [1:0]        col_off_reg, col_off_next;  // neighbourhood column of the read being issued
    logic              shift_en;
    logic              result_load;
    logic [ADDR_W-1:0] rd_addr_next;
    logic [ADDR_W-1:0] wr_addr_calc;
    logic [3:0]        slot_cur;
    logic              pend_valid_reg;             // read data for pend_slot_reg is on i_rd_data
    logic [3:0]        pend_slot_reg;
    logic [7:0]        pix_reg [0:8];

    // A 3-read fetch uses col_off = 2 throughout, so the same slot/address
    // formula covers both the full 9-read load and the single new column.
    assign slot_cur     = 4'(row_off_reg) * 4'd3 + 4'(col_off_reg);
    assign rd_addr_next = (r_next - ONE + ADDR_W'(row_off_next)) * W_A
                        + (c_next - ONE + ADDR_W'(col_off_next));
    assign wr_addr_calc = OUT_BASE + r_reg * W_A + c_reg;

    // Next-state, scan position and fetch sequencing.
    always_comb begin
        state_next   = state_reg;
        r_next       = r_reg;
        c_next       = c_reg;
        cnt_next     = cnt_reg;
        row_off_next = row_off_reg;
        col_off_next = col_off_reg;
        shift_en     = 1'b0;
        result_load  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    state_next   = S_FETCH;
                    r_next       = ONE;
                    c_next       = ONE;
                    cnt_next     = 4'd9;
                    row_off_next = 2'd0;
                    col_off_next = 2'd0;
                end
            end
            S_FETCH: begin
                if (row_off_reg == 2'd2 && col_off_reg == 2'd2) begin
                    state_next = S_CAPTURE;
                end else if (cnt_reg == 4'd9 && col_off_reg != 2'd2) begin
                    col_off_next = col_off_reg + 2'd1;
                end else begin
                    row_off_next = row_off_reg + 2'd1;
                    if (cnt_reg == 4'd9) begin
                        col_off_next = 2'd0;
                    end
                end
            end
            S_CAPTURE: state_next = S_START;
            S_START:   state_next = S_WAIT;
            S_WAIT: begin
                if (i_gradient_data_ready) begin
                    result_load = 1'b1;
                    state_next  = S_WRITE;
                end
            end
            S_WRITE:   state_next = S_NEXT;
            S_NEXT: begin
                if (c_reg < C_LAST) begin
                    c_next       = c_reg + ONE;
                    shift_en     = 1'b1;
                    cnt_next     = 4'd3;
                    row_off_next = 2'd0;
                    col_off_next = 2'd2;
                    state_next   = S_FETCH;
                end else if (r_reg < R_LAST) begin
                    c_next       = ONE;
                    r_next       = r_reg + ONE;
                    cnt_next     = 4'd9;
                    row_off_next = 2'd0;
                    col_off_next = 2'd0;
                    state_next   = S_FETCH;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // State, counters and state-decoded output flops.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg        <= S_IDLE;
            r_reg            <= '0;
            c_reg            <= '0;
            cnt_reg          <= '0;
            row_off_reg      <= '0;
            col_off_reg      <= '0;
            pend_valid_reg   <= 1'b0;
            pend_slot_reg    <= '0;
            o_rd_en          <= 1'b0;
            o_rd_addr        <= '0;
            o_gradient_start <= 1'b0;
            o_wr_en          <= 1'b0;
            o_wr_addr        <= '0;
            o_wr_data        <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            state_reg        <= state_next;
            r_reg            <= r_next;
            c_reg            <= c_next;
            cnt_reg          <= cnt_next;
            row_off_reg      <= row_off_next;
            col_off_reg      <= col_off_next;
            pend_valid_reg   <= (state_reg == S_FETCH);
            pend_slot_reg    <= slot_cur;
            o_rd_en          <= (state_next == S_FETCH);
            if (state_next == S_FETCH) begin
                o_rd_addr <= rd_addr_next;
            end
            o_gradient_start <= (state_next == S_START);
            o_wr_en          <= (state_next == S_WRITE);
            o_done           <= (state_next == S_DONE);
            // Busy stays high through the DONE cycle and drops on return to IDLE.
            o_busy           <= (state_next != S_IDLE);
            if (result_load) begin
                o_wr_data <= i_processed_sum;
                o_wr_addr <= wr_addr_calc;
            end
        end
    end

    // Window storage: capture returning read data into its slot, or shift left a column.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 9; i++) begin
                pix_reg[i] <= '0;
            end
        end else if (pend_valid_reg) begin
            pix_reg[pend_slot_reg] <= i_rd_data;
        end else if (shift_en) begin
            for (int i = 0; i < 3; i++) begin
                pix_reg[3*i]   <= pix_reg[3*i+1];
                pix_reg[3*i+1] <= pix_reg[3*i+2];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_window
            assign o_window[gi*8 +: 8] = pix_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_edge_window_controller.sv
// Testbench for edge_window_controller on a 4x4 image: memory and Sobel engine
// models, a negedge monitor, directed vector table, random frames and
// hand-written stray-ready / re-start / mid-frame reset sequences.
module tb_edge_window_controller;

    localparam int          W  = 4;
    localparam int          H  = 4;
    localparam int          AW = 16;
    localparam logic [15:0] OB = 16'h0400;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          i_start;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [7:0]    i_rd_data;
    logic [71:0]   o_window;
    logic          o_gradient_start;
    logic          i_gradient_data_ready;
    logic [7:0]    i_processed_sum;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [7:0]    o_wr_data;
    logic          o_busy;
    logic          o_done;

    always #5 clk = ~clk;

    edge_window_controller #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .OUT_BASE(OB)) dut (
        .clk(clk), .n_rst(n_rst), .i_start(i_start),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_window(o_window), .o_gradient_start(o_gradient_start),
        .i_gradient_data_ready(i_gradient_data_ready), .i_processed_sum(i_processed_sum),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    function automatic logic [7:0] sobel(input logic [71:0] w);
        int p [9];
        int gx, gy, m;
        for (int i = 0; i < 9; i++) p[i] = int'(w[i*8 +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = gx + gy;
        if (m > 255) m = 255;
        return 8'(m);
    endfunction

    // Image memory: data one cycle after the read strobe, junk otherwise.
    logic [7:0] img [0:15];
    always @(posedge clk) i_rd_data <= o_rd_en ? img[o_rd_addr[3:0]] : 8'h5A;

    // Engine model: ready eng_lat cycles after the start pulse.
    int         eng_lat  = 1;
    int         eng_left = 0;
    logic [7:0] eng_sum  = 8'h00;
    logic       stray;
    always @(posedge clk) begin
        if (o_gradient_start) begin
            eng_left <= eng_lat;
            eng_sum  <= sobel(o_window);
        end else if (eng_left > 0) begin
            eng_left <= eng_left - 1;
        end
    end
    assign i_gradient_data_ready = (eng_left == 1) || stray;
    assign i_processed_sum       = eng_sum;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor (written only here; the main process reads deltas).
    int          rd_q [$];
    int          wa_q [$];
    int          wd_q [$];
    int          wc_q [$];
    logic [71:0] win_q [$];
    int          n_starts = 0, n_done = 0, v_win = 0, v_rd = 0, v_both = 0;
    initial begin : monitor
        logic        waiting;
        logic [71:0] hold;
        waiting = 1'b0;
        hold    = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                waiting = 1'b0;
            end else begin
                if (o_rd_en) rd_q.push_back(int'(o_rd_addr));
                if (o_wr_en) begin
                    wa_q.push_back(int'(o_wr_addr));
                    wd_q.push_back(int'(o_wr_data));
                    wc_q.push_back(cyc);
                end
                if (o_done) n_done++;
                if (o_gradient_start && o_wr_en) v_both++;
                if (waiting) begin
                    if (o_window != hold) v_win++;
                    if (o_rd_en) v_rd++;
                    if (i_gradient_data_ready) waiting = 1'b0;
                end
                if (o_gradient_start) begin
                    n_starts++;
                    hold = o_window;
                    win_q.push_back(o_window);
                    waiting = 1'b1;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] neigh(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                w[(dy*3+dx)*8 +: 8] = img[(r-1+dy)*W + (c-1+dx)];
        return w;
    endfunction

    // Runs one frame and checks it against the scan-order reference model.
    task automatic run_frame(input int lat, input bit stray_en, input int repulse);
        int rb, wb, sb, db, vw, vr, vb, na, ne, idle_bad;
        bit done_seen;
        int exp_rd [$];
        int exp_wa [$];
        int exp_wd [$];
        int exp_gap [$];
        rb = rd_q.size(); wb = wa_q.size(); sb = n_starts; db = n_done;
        vw = v_win; vr = v_rd; vb = v_both;
        done_seen = 1'b0;
        eng_lat = lat;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        check("first_rd_en", 128'(o_rd_en), 128'(1));
        check("busy_after_start", 128'(o_busy), 128'(1));
        for (int k = 0; k < 5000; k++) begin
            if (o_done) begin
                done_seen = 1'b1;
                break;
            end
            stray   = stray_en && o_rd_en;
            i_start = (k == repulse);
            @(negedge clk);
        end
        stray = 1'b0; i_start = 1'b0;
        @(negedge clk);
        check("done_seen", 128'(done_seen), 128'(1));
        check("busy_after_done", 128'({o_busy, o_done}), 128'(0));
        for (int r = 1; r <= H-2; r++) begin
            for (int c = 1; c <= W-2; c++) begin
                if (c == 1) begin
                    for (int dy = 0; dy < 3; dy++)
                        for (int dx = 0; dx < 3; dx++) exp_rd.push_back((r-1+dy)*W + dx);
                end else begin
                    for (int dy = 0; dy < 3; dy++) exp_rd.push_back((r-1+dy)*W + c + 1);
                end
                exp_wa.push_back(int'(OB) + r*W + c);
                exp_wd.push_back(int'(sobel(neigh(r, c))));
                exp_gap.push_back((c == 1) ? lat + 13 : lat + 7);
            end
        end
        na = rd_q.size() - rb;
        check("rd_count", 128'(na), 128'(exp_rd.size()));
        for (int i = 0; i < na && i < exp_rd.size(); i++)
            check($sformatf("rd_addr[%0d]", i), 128'(rd_q[rb+i]), 128'(exp_rd[i]));
        na = wa_q.size() - wb;
        ne = exp_wa.size();
        check("wr_count", 128'(na), 128'(ne));
        for (int i = 0; i < na && i < ne; i++) begin
            check($sformatf("wr_addr[%0d]", i), 128'(wa_q[wb+i]), 128'(exp_wa[i]));
            check($sformatf("wr_data[%0d]", i), 128'(wd_q[wb+i]), 128'(exp_wd[i]));
            if (i > 0)
                check($sformatf("wr_gap[%0d]", i), 128'(wc_q[wb+i] - wc_q[wb+i-1]), 128'(exp_gap[i]));
        end
        check("start_count", 128'(n_starts - sb), 128'(ne));
        check("done_count", 128'(n_done - db), 128'(1));
        check("win_stable_viol", 128'(v_win - vw), 128'(0));
        check("rd_in_wait_viol", 128'(v_rd - vr), 128'(0));
        check("start_and_wr_viol", 128'(v_both - vb), 128'(0));
        idle_bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_busy || o_rd_en) idle_bad++;
        end
        check("idle_after_frame", 128'(idle_bad), 128'(0));
        $display("frame lat=%0d stray=%0d repulse=%0d reads=%0d writes=%0d", lat, stray_en, repulse, rd_q.size() - rb, na);
    endtask

    typedef struct {
        logic [7:0]  col0;
        logic [7:0]  col2;
        logic [7:0]  row0;
        int          lat;
        logic [71:0] exp_win;
        logic [7:0]  exp_first;
    } vec_t;

    vec_t vecs [5];
    int   exp_row1 [12];
    int   exp_wr4 [4];

    initial begin
        int wb, db, rb, bad, bound;
        vecs[0] = '{8'd0,  8'd0,   8'd0,  1, 72'h000000000000000000, 8'd0};
        vecs[1] = '{8'd0,  8'd10,  8'd0,  3, 72'h0A00000A00000A0000, 8'd40};
        vecs[2] = '{8'd0,  8'd255, 8'd0,  2, 72'hFF0000FF0000FF0000, 8'd255};
        vecs[3] = '{8'd10, 8'd0,   8'd0,  4, 72'h00000A00000A00000A, 8'd40};
        vecs[4] = '{8'd0,  8'd0,   8'd20, 5, 72'h000000000000141414, 8'd80};
        exp_row1 = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 3, 7, 11};
        exp_wr4  = '{'h405, 'h406, 'h409, 'h40A};

        i_start = 1'b0; stray = 1'b0; n_rst = 1'b1;
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
        #2 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 128'({o_rd_en, o_rd_addr, o_window, o_gradient_start, o_wr_en,
                                     o_wr_addr, o_wr_data, o_busy, o_done}), 128'(0));
        n_rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 128'(o_busy), 128'(0));

        // Directed vector table.
        for (int v = 0; v < 5; v++) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    img[y*W+x] = ((x == 0) ? vecs[v].col0 : 8'd0) + ((x == 2) ? vecs[v].col2 : 8'd0)
                               + ((y == 0) ? vecs[v].row0 : 8'd0);
            rb = rd_q.size(); wb = wa_q.size(); db = win_q.size();
            run_frame(vecs[v].lat, 1'b0, -1);
            if (win_q.size() > db) check($sformatf("vec%0d_window", v), 128'(win_q[db]), 128'(vecs[v].exp_win));
            else check($sformatf("vec%0d_window_seen", v), 128'(0), 128'(1));
            if (wd_q.size() > wb) check($sformatf("vec%0d_first_data", v), 128'(wd_q[wb]), 128'(vecs[v].exp_first));
            else check($sformatf("vec%0d_first_seen", v), 128'(0), 128'(1));
            if (v == 0) begin
                for (int i = 0; i < 12 && rb + i < rd_q.size(); i++)
                    check($sformatf("row1_addr[%0d]", i), 128'(rd_q[rb+i]), 128'(exp_row1[i]));
                for (int i = 0; i < 4 && wb + i < wa_q.size(); i++)
                    check($sformatf("wr4_addr[%0d]", i), 128'(wa_q[wb+i]), 128'(exp_wr4[i]));
            end
        end

        // Random images and engine latencies.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
            run_frame(int'($urandom_range(1, 8)), 1'b0, -1);
        end

        // Slow engine with stray ready pulses throughout every fetch.
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        run_frame(50, 1'b1, -1);

        // Re-pulse of i_start while busy.
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        run_frame(6, 1'b0, 30);

        // Reset asserted during WAIT aborts the frame.
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(1, 255));
        eng_lat = 50;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        bound = 0;
        while (!o_gradient_start && bound < 500) begin
            @(negedge clk);
            bound++;
        end
        check("reset_seq_start_seen", 128'(o_gradient_start), 128'(1));
        repeat (10) @(negedge clk);
        wb = wa_q.size(); db = n_done;
        n_rst = 1'b0;
        #1;
        check("abort_outputs", 128'({o_rd_en, o_rd_addr, o_window, o_gradient_start, o_wr_en,
                                     o_wr_addr, o_wr_data, o_busy, o_done}), 128'(0));
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_wr_en || o_done || o_busy || o_rd_en) bad++;
        end
        check("abort_quiet", 128'(bad), 128'(0));
        check("abort_writes", 128'(wa_q.size() - wb), 128'(0));
        check("abort_done", 128'(n_done - db), 128'(0));

        // Fresh start after the abort runs a full frame.
        run_frame(3, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_window_controller.md
# edge_window_controller

Scan controller for the Sobel `edge_detection` engine. It walks every interior pixel of an IMG_W x IMG_H 8-bit image held in an external single-port read memory and assembles the 3x3 neighbourhood into a sliding window register. For each pixel it runs one `edge_detection` transaction (start pulse, then wait for ready) and writes the returned magnitude to an output buffer. It sits between the image SRAM and the engine and is the only block that drives `i_gradient_start` and P0..P8.

## Interface
- IMG_W, 16: image width in pixels, must be ≥3.
- IMG_H, 16: image height in pixels, must be ≥3.
- ADDR_W, 16: memory address width.
- OUT_BASE, 16'h0400: base address of the output buffer.

Ports:
- clk  in  1  system clock. One clock domain; all flops rise-edge.
- n_rst  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle request to process a frame; ignored while busy.
- o_rd_en  out  1  memory read strobe.
- o_rd_addr  out  ADDR_W  read address, y*IMG_W + x.
- i_rd_data  in  8  read data, valid exactly one cycle after o_rd_en.
- o_window  out  72  P0 in [7:0] … P8 in [71:64], row-major.
  - P0..P2 = row r-1, cols c-1..c+1.
  - P3..P5 = row r.
  - P6..P8 = row r+1.
- o_gradient_start  out  1  one-cycle start pulse to the engine.
- i_gradient_data_ready  in  1  engine done pulse.
- i_processed_sum  in  8  engine result, valid while ready is high.
- o_wr_en  out  1  output write strobe.
- o_wr_addr  out  ADDR_W  OUT_BASE + r*IMG_W + c.
- o_wr_data  out  8  result byte.
- o_busy  out  1  high from the cycle after an accepted i_start until DONE completes.
- o_done  out  1  one-cycle pulse after the last write.

## Operation
- Reset: every output, the window, r, c and all counters are 0; state is IDLE.
- Scan order: r runs 1..IMG_H-2 (outer loop) and c runs 1..IMG_W-2 (inner loop).
- FSM states and transitions:
  - IDLE: goes to FETCH on i_start. r=1, c=1, and the fetch count is set to 9.
  - FETCH: issues one read per cycle.
    - At c==1 it issues 9 reads in order P0,P1,…,P8.
    - Otherwise it issues 3 reads, for column c+1 (rows r-1, r, r+1).
    - Data returned for read k is captured the cycle after read k is issued. With the window shifted left, a 3-read fetch fills P2, P5 and P8.
    - After the last read it goes to CAPTURE.
  - CAPTURE: stores the final read byte, then goes to START.
  - START: o_gradient_start=1 for exactly one cycle, then goes to WAIT.
  - WAIT: holds o_window stable.
    - On i_gradient_data_ready it latches i_processed_sum into o_wr_data and goes to WRITE.
    - It waits with no timeout.
  - WRITE: o_wr_en=1 for one cycle, then goes to NEXT.
  - NEXT: advances the scan position.
    - If c<IMG_W-2: c++, shift the window left by one column (P0←P1, P1←P2, same for rows 2 and 3), set the fetch count to 3, go to FETCH.
    - Else if r<IMG_H-2: c=1, r++, set the fetch count to 9, go to FETCH.
    - Else go to DONE.
  - DONE: o_done=1 for one cycle, o_busy drops, then goes to IDLE.
- Address arithmetic is unsigned and modulo 2^ADDR_W. The read and write regions are not checked for overlap; that is the integrator's responsibility.
- i_start outside IDLE is ignored and is not queued.
- i_gradient_data_ready outside WAIT is ignored and captures nothing.
- o_rd_en is never asserted outside FETCH. o_gradient_start and o_wr_en are never asserted in the same cycle.
- Asserting n_rst mid-frame aborts immediately. No write or done pulse follows, and the next frame needs a fresh i_start.

## Timing
- o_rd_en, o_rd_addr, o_gradient_start, o_wr_* and o_done are all registered (state-decoded flops).
- Per pixel, with engine latency E cycles measured from the start pulse to ready:
  - First column of a row: 9 + 1 + 1 + E + 1 + 1 cycles.
  - Other columns: 3 + 1 + 1 + E + 1 + 1 cycles.
- o_window changes only in FETCH, CAPTURE and NEXT, so it is stable from START through WAIT.
- Between the i_start sample and the first o_rd_en there is 1 cycle.

## Test plan
- **3x3 all-zero image:**
  - Reads: 9 reads at addresses 0,1,2,3,4,5,6,7,8 (IMG_W=3).
  - Start: one start pulse.
  - Write: one write, addr OUT_BASE+4, data 0.
  - Done: o_done after the write.
- **3x3 image, column 2 = 10, all else 0, with the real engine:**
  - Window: o_window = 0x0A00000A00000A0000.
  - Result: written data 40 (Gx=40, Gy=0).
- **3x3 image, column 2 = 255:**
  - Result: engine saturates (Gx=1020), written data 255.
- **4x4 image (IMG_W=IMG_H=4):**
  - Total reads: exactly 24 reads (9+3 per row, two rows).
  - Row 1 addresses: 0,1,2,4,5,6,8,9,10, then 3,7,11.
  - Writes: 4 writes, at OUT_BASE+5, 6, 9, 10 in that order.
- **Engine model delays ready by 50 cycles:**
  - o_window is held constant throughout WAIT.
  - No o_rd_en in WAIT.
  - Stray ready pulses injected during FETCH produce no write.
- **Reset and start handling:**
  - Assert n_rst during WAIT: all outputs are 0 immediately, and there is no write or done pulse.
  - A re-pulse of i_start while busy: no effect, and the write count is unchanged.
  - A new i_start after the reset runs a full frame.
